selector_arb_ctrl: RTL



---
 rtl/selector_ctrl_pkg.sv | 15 +
 rtl/rr_pick.sv | 24 ++
 rtl/selector_arb_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/selector_ctrl_pkg.sv
// Shared types and constants for the selector arbiter/sequencer.
// Used by selector_arb_ctrl and its round-robin picker.
package selector_ctrl_pkg;

  localparam int SEL_ADDR_W = 8;
  localparam int SEL_LINES  = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HOLD  = 2'd2,
    GAP   = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches from last+1,
// wrapping modulo N, and reports the first pending request.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] winner
);

  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(last) + k) % N]) begin
        found  = 1'b1;
        winner = IW'((int'(last) + k) % N);
      end
    end
  end

endmodule

// File: rtl/selector_arb_ctrl.sv
// Round-robin arbiter/sequencer in front of the 256-line selector.
// Optional grant locking is enabled by defining SELECTOR_ARB_LOCK_EN.
module selector_arb_ctrl
  import selector_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 2,
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [SEL_ADDR_W*NUM_REQ-1:0] req_addr,
`ifdef SELECTOR_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            req_lock,
`endif
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [SEL_ADDR_W-1:0]         sel_addr,
  output logic                          sel_en,
  output logic [IW-1:0]                 grant_id,
  output logic                          busy
);

  state_t state, state_n;

  logic [SEL_ADDR_W-1:0] sel_addr_n;
  logic [IW-1:0]         grant_n;
  logic [IW-1:0]         last, last_n;
  logic [IW-1:0]         winner;
  logic [CW-1:0]         hold_cnt, hold_cnt_n;
  logic [NUM_REQ-1:0]    ready_n;
  logic                  found;
  logic                  lock_hit;

  function automatic logic [SEL_ADDR_W-1:0] addr_of(
    input logic [IW-1:0] i
  );
    return req_addr[SEL_ADDR_W*int'(i) +: SEL_ADDR_W];
  endfunction

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req    (req_valid),
    .last   (last),
    .found  (found),
    .winner (winner)
  );

`ifdef SELECTOR_ARB_LOCK_EN
  assign lock_hit = req_lock[grant_id] & req_valid[grant_id];
`else
  assign lock_hit = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    sel_addr_n = sel_addr;
    grant_n    = grant_id;
    last_n     = last;
    hold_cnt_n = hold_cnt;
    ready_n    = '0;
    unique case (state)
      IDLE: begin
        if (found) begin
          sel_addr_n = addr_of(winner);
          grant_n    = winner;
          state_n    = SETUP;
        end
      end
      SETUP: begin
        hold_cnt_n = '0;
        state_n    = HOLD;
      end
      HOLD: begin
        if (hold_cnt == CW'(HOLD_CYCLES - 1)) begin
          state_n = GAP;
        end else begin
          hold_cnt_n = hold_cnt + CW'(1);
        end
      end
      GAP: begin
        // A lock chain keeps the pointer so others wait their turn after it
        if (lock_hit) begin
          sel_addr_n = addr_of(grant_id);
          state_n    = SETUP;
        end else begin
          last_n  = grant_id;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n == GAP) begin
      ready_n[grant_n] = 1'b1;
    end
  end

  // Outputs are registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel_addr  <= '0;
      grant_id  <= '0;
      last      <= IW'(NUM_REQ - 1);
      hold_cnt  <= '0;
      sel_en    <= 1'b0;
      req_ready <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      sel_addr  <= sel_addr_n;
      grant_id  <= grant_n;
      last      <= last_n;
      hold_cnt  <= hold_cnt_n;
      sel_en    <= (state_n == HOLD);
      req_ready <= ready_n;
      busy      <= (state_n != IDLE);
    end
  end

endmodule
